// File: rtl/axi_pkg.sv
// Shared AXI definitions for the 2x1 read arbiter: FSM encodings,
// response/burst codes and the fixed-width parts of the AR and R bundles.
// AXI_ARB_RR_EN (when defined) selects round-robin read arbitration.
package axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_GNT0 = 2'b01,
        R_GNT1 = 2'b10
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // Address, ID and data widths are per-instance parameters, so only the
    // fixed-width control fields of each channel are bundled here.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_bundle_t;

    typedef struct packed {
        logic [1:0] resp;
        logic       last;
    } r_bundle_t;

endpackage

// File: rtl/axi_arb_sel.sv
// Combinational read grant selection between two AR requesters.
// Fixed priority (M1 over M0) by default; with AXI_ARB_RR_EN defined the
// master that did not win last time wins a tie.
module axi_arb_sel (
    input  logic arvalid0,
    input  logic arvalid1,
`ifdef AXI_ARB_RR_EN
    input  logic last_gnt,
`endif
    output logic req_any,
    output logic gnt1
);

    // Pick the winner; gnt1 is only meaningful when req_any is set
    always_comb begin
        req_any = arvalid0 | arvalid1;
`ifdef AXI_ARB_RR_EN
        gnt1    = arvalid1 & (~arvalid0 | ~last_gnt);
`else
        gnt1    = arvalid1;
`endif
    end

endmodule

// File: rtl/axi_rd_arbiter_2x1.sv
// Two-master to one-slave AXI4 arbiter: M0 (IFU, reads) and M1 (LSU,
// reads and writes) share one RAM slave. Reads are granted one burst at a
// time and held until the last beat; writes pass straight from M1, with at
// most one write outstanding, and no new read is granted while it is open.
// AXI_ARB_RR_EN (when defined) makes the read arbitration round-robin.
module axi_rd_arbiter_2x1
    import axi_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 64,
    parameter int IDW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    // M0 read
    input  logic              m0_arvalid,
    input  logic [AWIDTH-1:0] m0_araddr,
    input  logic [IDW-1:0]    m0_arid,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic [IDW-1:0]    m0_rid,
    input  logic              m0_rready,
    // M1 read
    input  logic              m1_arvalid,
    input  logic [AWIDTH-1:0] m1_araddr,
    input  logic [IDW-1:0]    m1_arid,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic [IDW-1:0]    m1_rid,
    input  logic              m1_rready,
    // M1 write
    input  logic              m1_awvalid,
    input  logic [AWIDTH-1:0] m1_awaddr,
    input  logic [IDW-1:0]    m1_awid,
    input  logic [7:0]        m1_awlen,
    input  logic [2:0]        m1_awsize,
    input  logic [1:0]        m1_awburst,
    output logic              m1_awready,
    input  logic              m1_wvalid,
    input  logic [DWIDTH-1:0] m1_wdata,
    input  logic [DWIDTH/8-1:0] m1_wstrb,
    input  logic              m1_wlast,
    output logic              m1_wready,
    output logic              m1_bvalid,
    output logic [1:0]        m1_bresp,
    output logic [IDW-1:0]    m1_bid,
    input  logic              m1_bready,
    // Slave read
    output logic              s_arvalid,
    output logic [AWIDTH-1:0] s_araddr,
    output logic [IDW-1:0]    s_arid,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DWIDTH-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic [IDW-1:0]    s_rid,
    output logic              s_rready,
    // Slave write
    output logic              s_awvalid,
    output logic [AWIDTH-1:0] s_awaddr,
    output logic [IDW-1:0]    s_awid,
    output logic [7:0]        s_awlen,
    output logic [2:0]        s_awsize,
    output logic [1:0]        s_awburst,
    input  logic              s_awready,
    output logic              s_wvalid,
    output logic [DWIDTH-1:0] s_wdata,
    output logic [DWIDTH/8-1:0] s_wstrb,
    output logic              s_wlast,
    input  logic              s_wready,
    input  logic              s_bvalid,
    input  logic [1:0]        s_bresp,
    input  logic [IDW-1:0]    s_bid,
    output logic              s_bready
);

    rd_state_t  rd_state, rd_next;
    wr_state_t  wr_state, wr_next;
    logic       ar_done, ar_done_next;
    logic       w_busy;
    logic       req_any, gnt1;
    ar_bundle_t m0_arb, m1_arb;
    r_bundle_t  s_rb;

    assign m0_arb = '{len: m0_arlen, size: m0_arsize, burst: m0_arburst};
    assign m1_arb = '{len: m1_arlen, size: m1_arsize, burst: m1_arburst};
    assign s_rb   = '{resp: s_rresp, last: s_rlast};
    assign w_busy = (wr_state == W_BUSY);

`ifdef AXI_ARB_RR_EN
    logic last_gnt, last_gnt_next;

    axi_arb_sel u_sel (
        .arvalid0 (m0_arvalid),
        .arvalid1 (m1_arvalid),
        .last_gnt (last_gnt),
        .req_any  (req_any),
        .gnt1     (gnt1)
    );

    // Remember which master was granted last so the other wins a tie
    always_ff @(posedge clk) begin
        if (rst) last_gnt <= 1'b0;
        else     last_gnt <= last_gnt_next;
    end

    // Update the round-robin pointer on every grant decision
    always_comb begin
        last_gnt_next = last_gnt;
        if (rd_state == R_IDLE && !w_busy && req_any) last_gnt_next = gnt1;
    end
`else
    axi_arb_sel u_sel (
        .arvalid0 (m0_arvalid),
        .arvalid1 (m1_arvalid),
        .req_any  (req_any),
        .gnt1     (gnt1)
    );
`endif

    // Read/write FSM state and the one-AR-per-grant flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
            ar_done  <= 1'b0;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
            ar_done  <= ar_done_next;
        end
    end

    // Read FSM: grant from idle, then route AR/R of the granted master only
    always_comb begin
        rd_next      = rd_state;
        ar_done_next = ar_done;
        s_arvalid    = 1'b0;
        s_araddr     = '0;
        s_arid       = '0;
        {s_arlen, s_arsize, s_arburst} = '0;
        s_rready     = 1'b0;
        m0_arready   = 1'b0;
        m1_arready   = 1'b0;
        m0_rvalid    = 1'b0;
        m0_rdata     = '0;
        m0_rid       = '0;
        {m0_rresp, m0_rlast} = '0;
        m1_rvalid    = 1'b0;
        m1_rdata     = '0;
        m1_rid       = '0;
        {m1_rresp, m1_rlast} = '0;
        case (rd_state)
            R_IDLE: begin
                ar_done_next = 1'b0;
                // Registered w_busy: an AW accepted this cycle does not stop the grant
                if (!w_busy && req_any) rd_next = gnt1 ? R_GNT1 : R_GNT0;
            end
            R_GNT0: begin
                s_arvalid  = m0_arvalid & ~ar_done;
                s_araddr   = m0_araddr;
                s_arid     = m0_arid;
                {s_arlen, s_arsize, s_arburst} = m0_arb;
                m0_arready = s_arready & ~ar_done;
                m0_rvalid  = s_rvalid;
                m0_rdata   = s_rdata;
                m0_rid     = s_rid;
                {m0_rresp, m0_rlast} = s_rb;
                s_rready   = m0_rready;
                if (m0_arvalid && !ar_done && s_arready) ar_done_next = 1'b1;
                if (s_rvalid && m0_rready && s_rlast)    rd_next = R_IDLE;
            end
            R_GNT1: begin
                s_arvalid  = m1_arvalid & ~ar_done;
                s_araddr   = m1_araddr;
                s_arid     = m1_arid;
                {s_arlen, s_arsize, s_arburst} = m1_arb;
                m1_arready = s_arready & ~ar_done;
                m1_rvalid  = s_rvalid;
                m1_rdata   = s_rdata;
                m1_rid     = s_rid;
                {m1_rresp, m1_rlast} = s_rb;
                s_rready   = m1_rready;
                if (m1_arvalid && !ar_done && s_arready) ar_done_next = 1'b1;
                if (s_rvalid && m1_rready && s_rlast)    rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Write FSM: one outstanding write, AW blocked until its B returns
    always_comb begin
        wr_next    = wr_state;
        s_awvalid  = 1'b0;
        m1_awready = 1'b0;
        if (wr_state == W_IDLE) begin
            s_awvalid  = m1_awvalid;
            m1_awready = s_awready;
            if (m1_awvalid && s_awready) wr_next = W_BUSY;
        end else begin
            if (s_bvalid && m1_bready) wr_next = W_IDLE;
        end
    end

    assign s_awaddr  = m1_awaddr;
    assign s_awid    = m1_awid;
    assign s_awlen   = m1_awlen;
    assign s_awsize  = m1_awsize;
    assign s_awburst = m1_awburst;
    assign s_wvalid  = m1_wvalid;
    assign s_wdata   = m1_wdata;
    assign s_wstrb   = m1_wstrb;
    assign s_wlast   = m1_wlast;
    assign m1_wready = s_wready;
    assign m1_bvalid = s_bvalid;
    assign m1_bresp  = s_bresp;
    assign m1_bid    = s_bid;
    assign s_bready  = m1_bready;

endmodule

// File: tb/tb_axi_rd_arbiter_2x1.sv
// Testbench for axi_rd_arbiter_2x1: behavioural AXI RAM slave, read-beat
// scoreboard fed when requests are issued, and directed scenarios.
module tb_axi_rd_arbiter_2x1;
    import axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
    logic [AW-1:0] m0_araddr;
    logic [IW-1:0] m0_arid, m0_rid;
    logic [7:0]    m0_arlen;
    logic [2:0]    m0_arsize;
    logic [1:0]    m0_arburst, m0_rresp;
    logic [DW-1:0] m0_rdata;
    logic          m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
    logic [AW-1:0] m1_araddr;
    logic [IW-1:0] m1_arid, m1_rid;
    logic [7:0]    m1_arlen;
    logic [2:0]    m1_arsize;
    logic [1:0]    m1_arburst, m1_rresp;
    logic [DW-1:0] m1_rdata;
    logic          m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready;
    logic          m1_bvalid, m1_bready;
    logic [AW-1:0] m1_awaddr;
    logic [IW-1:0] m1_awid, m1_bid;
    logic [7:0]    m1_awlen;
    logic [2:0]    m1_awsize;
    logic [1:0]    m1_awburst, m1_bresp;
    logic [DW-1:0] m1_wdata;
    logic [DW/8-1:0] m1_wstrb;
    logic          s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [AW-1:0] s_araddr;
    logic [IW-1:0] s_arid, s_rid;
    logic [7:0]    s_arlen;
    logic [2:0]    s_arsize;
    logic [1:0]    s_arburst, s_rresp;
    logic [DW-1:0] s_rdata;
    logic          s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
    logic          s_bvalid, s_bready;
    logic [AW-1:0] s_awaddr;
    logic [IW-1:0] s_awid, s_bid;
    logic [7:0]    s_awlen;
    logic [2:0]    s_awsize;
    logic [1:0]    s_awburst, s_bresp;
    logic [DW-1:0] s_wdata;
    logic [DW/8-1:0] s_wstrb;

    axi_rd_arbiter_2x1 #(.AWIDTH(AW), .DWIDTH(DW), .IDW(IW)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_awready(m1_awready), .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid), .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready)
    );

    // Behavioural RAM slave: one burst at a time, data = {addr, 24'h0, beat}
    logic          sl_busy;
    logic [AW-1:0] sl_addr;
    logic [7:0]    sl_len, sl_beat;
    logic [IW-1:0] sl_id;

    assign s_arready = !sl_busy && !rst;
    assign s_rdata   = {sl_addr, 24'h0, sl_beat};
    assign s_rlast   = s_rvalid && (sl_beat == sl_len);
    assign s_rid     = sl_id;
    assign s_rresp   = RESP_OKAY;

    always @(posedge clk) begin
        if (rst) begin
            sl_busy  <= 1'b0;
            s_rvalid <= 1'b0;
            sl_beat  <= 8'd0;
            sl_addr  <= '0;
            sl_len   <= 8'd0;
            sl_id    <= '0;
        end else if (!sl_busy) begin
            if (s_arvalid && s_arready) begin
                sl_busy  <= 1'b1;
                sl_addr  <= s_araddr;
                sl_len   <= s_arlen;
                sl_id    <= s_arid;
                sl_beat  <= 8'd0;
                s_rvalid <= 1'b1;
            end
        end else if (s_rvalid && s_rready) begin
            if (sl_beat == sl_len) begin
                sl_busy  <= 1'b0;
                s_rvalid <= 1'b0;
            end else begin
                sl_beat <= sl_beat + 8'd1;
            end
        end
    end

    // Scoreboard entry: {master, data, last, id, resp}
    logic [71:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_burst(input logic m, input logic [AW-1:0] a,
                              input logic [7:0] len, input logic [IW-1:0] id);
        for (int b = 0; b <= int'(len); b++)
            exp_q.push_back({m, a, 24'h0, 8'(b), (b == int'(len)), id, RESP_OKAY});
    endtask

    task automatic check_beat(input logic m, input logic [DW-1:0] d, input logic l,
                              input logic [IW-1:0] id, input logic [1:0] resp);
        logic [71:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("r_beat", {m, d, l, id, resp}, e);
    endtask

    // Compare every delivered read beat against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_rvalid && m0_rready) check_beat(1'b0, m0_rdata, m0_rlast, m0_rid, m0_rresp);
            if (m1_rvalid && m1_rready) check_beat(1'b1, m1_rdata, m1_rlast, m1_rid, m1_rresp);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q(input int n, input int bound);
        for (int i = 0; i < bound && exp_q.size() > n; i++) @(negedge clk);
        chk("drain", exp_q.size(), n);
    endtask

    task automatic ar_req(input logic m, input logic [AW-1:0] a,
                          input logic [7:0] len, input logic [IW-1:0] id);
        logic ok;
        ok = 1'b0;
        if (m) begin
            m1_araddr = a; m1_arlen = len; m1_arid = id;
            m1_arsize = 3'd3; m1_arburst = BURST_INCR; m1_arvalid = 1'b1;
        end else begin
            m0_araddr = a; m0_arlen = len; m0_arid = id;
            m0_arsize = 3'd3; m0_arburst = BURST_INCR; m0_arvalid = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m ? m1_arready : m0_arready) begin
                ok = 1'b1;
                break;
            end
        end
        chk(m ? "ar_accept_m1" : "ar_accept_m0", ok, 1'b1);
        tick;
        if (m) m1_arvalid = 1'b0;
        else   m0_arvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
        m0_rready = 0;
        m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
        m1_rready = 0;
        m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = '0; m1_awburst = '0;
        m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_bid = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valids", {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready,
                             s_awvalid, m1_awready, m1_bvalid, s_wvalid, m1_wready}, '0);
        chk("reset_data", {m0_rdata, s_araddr}, '0);
        tick;
        rst = 0;
        s_awready = 1; s_wready = 1;
        m0_rready = 1; m1_rready = 1; m1_bready = 1;
        tick;

        // M0 alone, 4-beat burst, one cycle of grant latency
        m0_araddr = 32'h8000_0000; m0_arlen = 8'd3; m0_arid = 4'd2;
        m0_arsize = 3'd3; m0_arburst = BURST_INCR; m0_arvalid = 1;
        push_burst(1'b0, 32'h8000_0000, 8'd3, 4'd2);
        @(negedge clk);
        chk("t1_no_ar_in_idle", s_arvalid, 1'b0);
        tick;
        @(negedge clk);
        chk("t1_ar_fwd", {s_arvalid, m0_arready, m1_arready}, 3'b110);
        chk("t1_araddr", {s_araddr, s_arlen, s_arid}, {32'h8000_0000, 8'd3, 4'd2});
        tick;
        m0_arvalid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_m1_quiet", m1_rvalid, 1'b0);
        end
        wait_q(0, 10);
        repeat (2) tick;

        // Both request together: M1 first, one idle cycle, then M0
        m0_araddr = 32'h8000_0040; m0_arlen = 8'd1; m0_arid = 4'd1; m0_arvalid = 1;
        m1_araddr = 32'h8000_1000; m1_arlen = 8'd0; m1_arid = 4'd3;
        m1_arsize = 3'd3; m1_arburst = BURST_INCR; m1_arvalid = 1;
        push_burst(1'b1, 32'h8000_1000, 8'd0, 4'd3);
        push_burst(1'b0, 32'h8000_0040, 8'd1, 4'd1);
        @(negedge clk);
        chk("t2_no_ar_in_idle", s_arvalid, 1'b0);
        tick;
        @(negedge clk);
        chk("t2_m1_first", {s_arvalid, s_araddr, m0_arready, m1_arready}, {1'b1, 32'h8000_1000, 2'b01});
        tick;
        m1_arvalid = 0;
        tick;
        @(negedge clk);
        chk("t2_idle_gap", {s_arvalid, m0_arready}, 2'b00);
        tick;
        @(negedge clk);
        chk("t2_m0_second", {s_arvalid, s_araddr, m0_arready}, {1'b1, 32'h8000_0040, 1'b1});
        tick;
        m0_arvalid = 0;
        wait_q(0, 10);
        repeat (2) tick;

        // After an M1 grant, a tie goes to M1 (fixed) or M0 (round-robin)
        push_burst(1'b1, 32'h8000_1040, 8'd0, 4'd5);
        ar_req(1'b1, 32'h8000_1040, 8'd0, 4'd5);
        wait_q(0, 10);
        repeat (2) tick;
`ifdef AXI_ARB_RR_EN
        push_burst(1'b0, 32'h8000_0400, 8'd1, 4'd8);
        push_burst(1'b1, 32'h8000_1400, 8'd0, 4'd9);
`else
        push_burst(1'b1, 32'h8000_1400, 8'd0, 4'd9);
        push_burst(1'b0, 32'h8000_0400, 8'd1, 4'd8);
`endif
        fork
            ar_req(1'b0, 32'h8000_0400, 8'd1, 4'd8);
            ar_req(1'b1, 32'h8000_1400, 8'd0, 4'd9);
        join
        wait_q(0, 20);
        repeat (2) tick;

        // Write with delayed B blocks new reads and a second AW
        m1_awvalid = 1; m1_awaddr = 32'h8000_2000; m1_awid = 4'd5; m1_awlen = 8'd0;
        m1_awsize = 3'd3; m1_awburst = BURST_INCR;
        m1_wvalid = 1; m1_wdata = 64'hDEAD_BEEF_0123_4567; m1_wstrb = 8'hFF; m1_wlast = 1;
        @(negedge clk);
        chk("t3_aw_fwd", {s_awvalid, m1_awready, s_wvalid, m1_wready}, 4'hF);
        chk("t3_aw_data", {s_awaddr, s_awid, s_wdata}, {32'h8000_2000, 4'd5, 64'hDEAD_BEEF_0123_4567});
        tick;
        m1_awaddr = 32'h8000_3000; m1_awid = 4'd7;
        m1_wvalid = 0; m1_wlast = 0;
        m0_araddr = 32'h8000_0080; m0_arlen = 8'd0; m0_arid = 4'd6;
        m0_arsize = 3'd3; m0_arburst = BURST_INCR; m0_arvalid = 1;
        push_burst(1'b0, 32'h8000_0080, 8'd0, 4'd6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_blocked", {s_arvalid, m1_awready, s_awvalid}, 3'b000);
            tick;
        end
        s_bvalid = 1; s_bresp = 2'b10; s_bid = 4'd5;
        @(negedge clk);
        chk("t3_b_fwd", {m1_bvalid, m1_bresp, m1_bid, s_bready}, {1'b1, 2'b10, 4'd5, 1'b1});
        chk("t3_blocked_at_b", {s_arvalid, m1_awready}, 2'b00);
        tick;
        s_bvalid = 0; s_bresp = 2'b00;
        @(negedge clk);
        chk("t3_aw2_open", {m1_awready, s_awvalid, s_arvalid, s_awaddr}, {3'b110, 32'h8000_3000});
        tick;
        m1_awvalid = 0;
        @(negedge clk);
        chk("t3_grant_with_aw", {s_arvalid, m0_arready, s_araddr}, {2'b11, 32'h8000_0080});
        tick;
        m0_arvalid = 0;
        wait_q(0, 10);
        tick;
        s_bvalid = 1; s_bid = 4'd7;
        @(negedge clk);
        chk("t3_b2_fwd", {m1_bvalid, m1_bid}, {1'b1, 4'd7});
        tick;
        s_bvalid = 0;
        @(negedge clk);
        chk("t3_w_idle", m1_awready, 1'b1);
        repeat (2) tick;

        // rready backpressure mid-burst; M1 waits for the whole burst
        push_burst(1'b0, 32'h8000_0100, 8'd3, 4'd1);
        ar_req(1'b0, 32'h8000_0100, 8'd3, 4'd1);
        m1_araddr = 32'h8000_1100; m1_arlen = 8'd0; m1_arid = 4'd4;
        m1_arsize = 3'd3; m1_arburst = BURST_INCR; m1_arvalid = 1;
        push_burst(1'b1, 32'h8000_1100, 8'd0, 4'd4);
        tick;
        m0_rready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_s_rready_low", {s_rready, m0_rvalid}, 2'b01);
            chk("t4_data_held", m0_rdata, {32'h8000_0100, 24'h0, 8'd1});
            chk("t4_m1_waits", {m1_arready, s_arvalid}, 2'b00);
            tick;
        end
        m0_rready = 1;
        wait_q(1, 20);
        ar_req(1'b1, 32'h8000_1100, 8'd0, 4'd4);
        wait_q(0, 10);
        repeat (2) tick;

        // Reset during the second beat of a 4-beat read
        push_burst(1'b0, 32'h8000_0200, 8'd3, 4'd3);
        ar_req(1'b0, 32'h8000_0200, 8'd3, 4'd3);
        tick;
        rst = 1;
        exp_q.delete();
        tick;
        rst = 0;
        @(negedge clk);
        chk("t5_valids_after_rst", {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid,
                                    s_rready, s_awvalid, m1_bvalid}, 8'h00);
        chk("t5_data_after_rst", m0_rdata, 64'h0);
        tick;
        push_burst(1'b1, 32'h8000_1200, 8'd1, 4'd2);
        ar_req(1'b1, 32'h8000_1200, 8'd1, 4'd2);
        wait_q(0, 10);
        repeat (2) tick;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter_2x1.md
Name: axi_rd_arbiter_2x1

Overview:
- Shares the single AXI4 RAM slave port between two masters.
- M0 is the IFU and issues reads only. M1 is the LSU and issues reads and writes.
- Read-address and read-data channels are arbitrated and locked per burst. The write channels pass straight from M1.
- Sits between the core's IFU/LSU bus interfaces and the AXI RAM slave.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 64, data width (32 or 64)
- IDW, 4, AXI ID width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_arvalid/m0_araddr/m0_arid/m0_arlen/m0_arsize/m0_arburst  in  1/AWIDTH/IDW/8/3/2  M0 AR request
- m0_arready  out  1  M0 AR accept
- m0_rvalid/m0_rdata/m0_rresp/m0_rlast/m0_rid  out  1/DWIDTH/2/1/IDW  M0 R return
- m0_rready  in  1  M0 R accept
- m1_ar*, m1_r*  same set as M0  M1 read channels
- m1_aw*/m1_w*/m1_bready  in  AXI4 widths  M1 write request, data and response accept
- m1_awready/m1_wready/m1_b*  out  AXI4 widths  M1 write accept and response
- s_ar*/s_rready  out  AXI4 widths  slave AR request, R accept
- s_arready/s_r*  in  AXI4 widths  slave AR accept, R return
- s_aw*/s_w*/s_bready  out  AXI4 widths  slave write request, data, B accept
- s_awready/s_wready/s_b*  in  AXI4 widths  slave write accept and response

Behaviour:
- Reset and handshake convention: rst is synchronous active-high on clk. Reset forces R_IDLE and W_IDLE. On the cycle after reset, all valid/ready outputs to masters and slave are 0 and data outputs are 0.
- Read FSM states: R_IDLE, R_GNT0, R_GNT1.
- R_IDLE:
  - If w_busy=0 and any m*_arvalid=1, register the grant and go to R_GNT0 or R_GNT1.
  - Fixed priority: M1 over M0.
  - No AR forwarding occurs in R_IDLE, so grant latency is 1 cycle.
- R_GNTx:
  - s_ar* = mx_ar*, and mx_arready = s_arready. The other master's arready = 0.
  - R: mx_r* = s_r* and s_rready = mx_rready. The other master's rvalid = 0.
  - Only one AR is forwarded per grant. An ar_done flag is set on the AR handshake, and s_arvalid = 0 after that.
  - Return to R_IDLE on s_rvalid & s_rready & s_rlast.
- Lock: the granted master keeps the grant for its whole burst (arlen+1 beats). The other master's arvalid is held pending and is not dropped.
- Write path:
  - m1_aw*/m1_w*/m1_b* are wired straight to s_aw*/s_w*/s_b*.
  - W FSM states: W_IDLE and W_BUSY.
  - W_IDLE -> W_BUSY on the AW handshake. W_BUSY -> W_IDLE on the B handshake.
  - w_busy = (state == W_BUSY).
  - A second AW is blocked while in W_BUSY (s_awvalid = 0, m1_awready = 0).
- Ordering: no new read grant is issued while w_busy=1. A read already granted completes normally.
- Simultaneous events:
  - AW handshake in the same cycle as a grant decision in R_IDLE: the grant proceeds, because the decision uses registered w_busy = 0.
  - r_done and a new arvalid in the same cycle: the next grant is made from R_IDLE on the following cycle. There is one idle cycle between bursts.
- Reset mid-burst: both FSMs go to IDLE immediately. No response is owed to masters; the slave is reset on the same rst.
- Write-path response: bresp is passed through and rresp is routed unchanged. No errors are generated internally.

Optional Feature:
- Macro: AXI_ARB_RR_EN.
- When defined: round-robin priority. A last_gnt register (reset 0 = M0) is updated on each grant, and the other master wins ties.
- When undefined: fixed priority, M1 over M0, and last_gnt is absent.

Decomposition:
- Shared package axi_pkg holds:
  - the R_IDLE/R_GNT0/R_GNT1 and W_IDLE/W_BUSY encodings;
  - the AXI resp codes (OKAY = 2'b00);
  - the burst code INCR = 2'b01;
  - typedefs for the AR bundle and R bundle structs.
- One sub-module, axi_arb_sel: combinational grant selection from (arvalid0, arvalid1, last_gnt), which encapsulates the fixed versus round-robin choice.

Test Plan:
- M0 alone: araddr=0x8000_0000, arlen=3. s_arvalid rises 1 cycle after m0_arvalid, and M0 receives 4 beats with rlast on the 4th. m1_rvalid stays 0 throughout.
- Both arvalid in the same cycle, fixed priority: M1 (0x8000_1000, len 0) is served first, then M0 after 1 idle cycle. With AXI_ARB_RR_EN and last_gnt=M1, M0 is served first.
- M1 write aw=0x8000_2000, len 0, with B delayed 5 cycles, while M0 asserts arvalid: no s_arvalid until 1 cycle after the B handshake.
- rready backpressure: M0 holds rready=0 for 3 cycles mid-burst. s_rready=0 in those cycles, the data is held, and M1's request waits.
- Second AW while W_BUSY: m1_awready=0 until the B handshake completes.
- rst asserted during beat 2 of a 4-beat read: next cycle all valids are 0, and a new request is granted normally afterwards.
